// File: rtl/uart_pkg.sv
// Shared UART types and default sizing used by the receive/transmit datapaths.
package uart_pkg;

    localparam int unsigned UART_BYTE_W    = 8;
    localparam int unsigned UART_RX_DEPTH  = 16;
    localparam int unsigned UART_RX_THRESH = 8;

    typedef logic [UART_BYTE_W-1:0] uart_byte_t;

endpackage : uart_pkg

// File: rtl/uart_rx_fifo_if.sv
// Receiver handshake plus CPU-side pop stream and status for the RX FIFO block.
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = UART_RX_DEPTH
) ();

    localparam int unsigned LW = $clog2(DEPTH) + 1;

    uart_byte_t        uart_rx_data;
    logic              uart_rx_ready;
    logic              uart_rx_ready_rst;
    uart_byte_t        rd_data;
    logic              rd_valid;
    logic              rd_en;
    logic [LW-1:0]     level;
    logic              rx_thresh;
    logic              overrun;
    logic              overrun_clr;

    // Environment side: receiver and bus/CPU consumer.
    modport master (
        output uart_rx_data, uart_rx_ready, rd_en, overrun_clr,
        input  uart_rx_ready_rst, rd_data, rd_valid, level, rx_thresh, overrun
    );

    // The FIFO block itself.
    modport slave (
        input  uart_rx_data, uart_rx_ready, rd_en, overrun_clr,
        output uart_rx_ready_rst, rd_data, rd_valid, level, rx_thresh, overrun
    );

endinterface : uart_rx_fifo_if

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO; qualifies push/pop requests against full/empty itself.
module uart_sync_fifo #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned LW    = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_req_i,
    input  logic             pop_req_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             valid_o,
    output logic [LW-1:0]    level_o,
    output logic [LW-1:0]    level_next_o,
    output logic             drop_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             valid_q;
    logic             full_c, pop_c, push_c;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
    always_comb begin
        full_c = (level_q == LW'(DEPTH));
        pop_c  = pop_req_i & valid_q;
        push_c = push_req_i & (~full_c | pop_c);
        drop_o = push_req_i & full_c & ~pop_c;
        wptr_d = push_c ? wptr_q + AW'(1) : wptr_q;
        rptr_d = pop_c  ? rptr_q + AW'(1) : rptr_q;
        level_d = level_q + LW'(push_c) - LW'(pop_c);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            valid_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            valid_q <= (level_d != '0);
        end
    end

    // Storage is intentionally left unreset.
    always_ff @(posedge clk_i) begin
        if (push_c) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o      = mem_q[rptr_q];
    assign valid_o      = valid_q;
    assign level_o      = level_q;
    assign level_next_o = level_d;

endmodule : uart_sync_fifo

// File: rtl/uart_rx_fifo.sv
// RX byte capture with one-cycle ack to the receiver, buffered into a show-ahead FIFO with status flags.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = UART_RX_DEPTH,
    parameter int unsigned AW     = $clog2(DEPTH),
    parameter int unsigned THRESH = UART_RX_THRESH
) (
    input  logic           uart_clk,
    input  logic           uart_rst_n,
    uart_rx_fifo_if.slave  bus
);

    localparam int unsigned LW = AW + 1;

    logic          ack_q, ack_d;
    logic          overrun_q, overrun_d;
    logic          thresh_q;
    logic          cap_c;
    logic          drop_c;
    logic [LW-1:0] level_c, level_next_c;
    uart_byte_t    rdata_c;
    logic          valid_c;

    // The receiver's ready is still high in the ack cycle; masking with the ack gives one capture per frame.
    always_comb begin
        cap_c     = bus.uart_rx_ready & ~ack_q;
        ack_d     = cap_c;
        overrun_d = overrun_q;
        if (bus.overrun_clr) begin
            overrun_d = 1'b0;
        end
        if (drop_c) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge uart_clk or negedge uart_rst_n) begin
        if (!uart_rst_n) begin
            ack_q     <= 1'b0;
            overrun_q <= 1'b0;
            thresh_q  <= 1'b0;
        end else begin
            ack_q     <= ack_d;
            overrun_q <= overrun_d;
            thresh_q  <= (level_next_c >= LW'(THRESH));
        end
    end

    uart_sync_fifo #(
        .WIDTH (UART_BYTE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (uart_clk),
        .rst_ni       (uart_rst_n),
        .push_req_i   (cap_c),
        .pop_req_i    (bus.rd_en),
        .wdata_i      (bus.uart_rx_data),
        .rdata_o      (rdata_c),
        .valid_o      (valid_c),
        .level_o      (level_c),
        .level_next_o (level_next_c),
        .drop_o       (drop_c)
    );

    assign bus.uart_rx_ready_rst = ack_q;
    assign bus.rd_data           = rdata_c;
    assign bus.rd_valid          = valid_c;
    assign bus.level             = level_c;
    assign bus.rx_thresh         = thresh_q;
    assign bus.overrun           = overrun_q;

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed receiver frames and pops, popped bytes checked against queued expectations.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int unsigned DEPTH = 16;

    logic clk;
    logic rst_n;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    uart_byte_t  sb_q[$];

    uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(.DEPTH(DEPTH), .THRESH(8)) dut (
        .uart_clk   (clk),
        .uart_rst_n (rst_n),
        .bus        (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted pop must match the oldest expected byte.
    always @(negedge clk) begin
        if (rst_n && bus.rd_en && bus.rd_valid) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_pop", 32'(bus.rd_data), 32'hFFFF_FFFF);
            end else begin
                chk("sb_rd_data", 32'(bus.rd_data), 32'(sb_q.pop_front()));
            end
        end
    end

    // Receiver model: raise ready, wait for the ack, clear ready on the edge after it.
    task automatic send_byte(input uart_byte_t b, input bit clr, input bit pop);
        int unsigned waited = 0;
        bus.uart_rx_data  = b;
        bus.uart_rx_ready = 1'b1;
        bus.overrun_clr   = clr;
        bus.rd_en         = pop;
        do begin
            tick();
            waited++;
            bus.overrun_clr = 1'b0;
            bus.rd_en       = 1'b0;
        end while (!bus.uart_rx_ready_rst && waited < 8);
        chk("ack_latency", waited, 1);
        tick();
        chk("ack_width", 32'(bus.uart_rx_ready_rst), 0);
        bus.uart_rx_ready = 1'b0;
    endtask

    task automatic pop_n(input int n);
        bus.rd_en = 1'b1;
        repeat (n) tick();
        bus.rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        uart_byte_t d;
        rst_n             = 1'b0;
        bus.uart_rx_data  = '0;
        bus.uart_rx_ready = 1'b0;
        bus.rd_en         = 1'b0;
        bus.overrun_clr   = 1'b0;
        repeat (2) tick();
        chk("rst_level",   32'(bus.level), 0);
        chk("rst_valid",   32'(bus.rd_valid), 0);
        chk("rst_ack",     32'(bus.uart_rx_ready_rst), 0);
        chk("rst_thresh",  32'(bus.rx_thresh), 0);
        chk("rst_overrun", 32'(bus.overrun), 0);
        rst_n = 1'b1;
        tick();

        // Single byte
        sb_q.push_back(8'hA5);
        send_byte(8'hA5, 1'b0, 1'b0);
        chk("single_valid", 32'(bus.rd_valid), 1);
        chk("single_level", 32'(bus.level), 1);
        chk("single_head",  32'(bus.rd_data), 32'hA5);
        pop_n(1);
        chk("single_empty_valid", 32'(bus.rd_valid), 0);
        chk("single_empty_level", 32'(bus.level), 0);

        // Burst to full, with threshold tracking
        for (int i = 0; i < 16; i++) begin
            sb_q.push_back(8'(i));
            send_byte(8'(i), 1'b0, 1'b0);
            chk("burst_level",  32'(bus.level), 32'(i + 1));
            chk("burst_thresh", 32'(bus.rx_thresh), (i + 1 >= 8) ? 1 : 0);
        end
        send_byte(8'hFF, 1'b0, 1'b0);
        chk("drop_overrun", 32'(bus.overrun), 1);
        chk("drop_level",   32'(bus.level), 16);

        // overrun_clr alone
        bus.overrun_clr = 1'b1;
        tick();
        bus.overrun_clr = 1'b0;
        chk("clr_alone", 32'(bus.overrun), 0);

        // Full with simultaneous capture and pop
        sb_q.push_back(8'h55);
        send_byte(8'h55, 1'b0, 1'b1);
        chk("fullpop_level",   32'(bus.level), 16);
        chk("fullpop_overrun", 32'(bus.overrun), 0);

        // Drop in the same cycle as overrun_clr: set wins
        send_byte(8'hEE, 1'b1, 1'b0);
        chk("clr_vs_drop", 32'(bus.overrun), 1);
        chk("clr_vs_drop_level", 32'(bus.level), 16);

        pop_n(16);
        chk("drain_level", 32'(bus.level), 0);
        chk("drain_valid", 32'(bus.rd_valid), 0);
        chk("drain_sb",    32'(sb_q.size()), 0);

        // Pointer wrap with byte/pop pairs
        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom_range(0, 255));
            sb_q.push_back(d);
            send_byte(d, 1'b0, 1'b0);
            chk("wrap_level_push", 32'(bus.level), 1);
            pop_n(1);
            chk("wrap_level_pop", 32'(bus.level), 0);
        end
        chk("wrap_sb", 32'(sb_q.size()), 0);

        // Reset with level=5 and ack high
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back(8'(8'h10 + i));
            send_byte(8'(8'h10 + i), 1'b0, 1'b0);
        end
        bus.uart_rx_data  = 8'h14;
        bus.uart_rx_ready = 1'b1;
        tick();
        chk("prerst_ack",     32'(bus.uart_rx_ready_rst), 1);
        chk("prerst_level",   32'(bus.level), 5);
        chk("prerst_overrun", 32'(bus.overrun), 1);
        #2;
        rst_n             = 1'b0;
        bus.uart_rx_ready = 1'b0;
        sb_q.delete();
        #1;
        chk("midrst_level",   32'(bus.level), 0);
        chk("midrst_valid",   32'(bus.rd_valid), 0);
        chk("midrst_ack",     32'(bus.uart_rx_ready_rst), 0);
        chk("midrst_overrun", 32'(bus.overrun), 0);
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        sb_q.push_back(8'h3C);
        send_byte(8'h3C, 1'b0, 1'b0);
        chk("postrst_level", 32'(bus.level), 1);
        chk("postrst_head",  32'(bus.rd_data), 32'h3C);
        pop_n(1);
        chk("postrst_sb", 32'(sb_q.size()), 0);
        chk("postrst_empty", 32'(bus.rd_valid), 0);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_uart_rx_fifo
